// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: per-LED GRB colour file, serialised MSB-first on each
// refresh, followed by a latch gap. Outputs are registered one cycle behind the FSM.
module ws2812_chain_driver #(
    parameter int NUM_LEDS = 8,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int TBIT     = 63,
    parameter int TRESET   = 3000,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_color,
    input  logic          refresh,
    output logic          busy,
    output logic          done,
    output logic          led_data_out
);

    localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int LW = (TRESET > 1) ? $clog2(TRESET) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [4:0]    bit_idx_q;
    logic [AW-1:0] led_idx_q;
    logic [LW-1:0] latch_cnt_q;
    logic [23:0]   shift_q;
    logic          pend_q;
    logic          fin_q;
    logic          busy_q;
    logic          done_q;
    logic          led_q;
    logic [23:0]   mem_q [NUM_LEDS];

    logic          wr_ok_d;
    logic          bit_hi_d;
    logic          bit_end_d;
    logic          last_led_d;
    logic [AW-1:0] next_idx_d;

    assign wr_ok_d    = wr_en && (32'(wr_addr) < 32'(NUM_LEDS));
    assign bit_hi_d   = bit_cnt_q < (shift_q[23] ? CW'(T1H) : CW'(T0H));
    assign bit_end_d  = (bit_cnt_q == CW'(TBIT - 1));
    assign last_led_d = (led_idx_q == AW'(NUM_LEDS - 1));
    assign next_idx_d = led_idx_q + AW'(1);

    // Out-of-range addresses are dropped; writes are accepted in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok_d) begin
            mem_q[wr_addr] <= wr_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            led_idx_q   <= '0;
            latch_cnt_q <= '0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE);
            done_q <= fin_q;
            fin_q  <= 1'b0;
            led_q  <= (state_q == ST_SEND) && bit_hi_d;
            if (refresh) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (refresh || pend_q) begin
                        state_q   <= ST_SEND;
                        pend_q    <= 1'b0;
                        led_idx_q <= '0;
                        bit_idx_q <= 5'd23;
                        bit_cnt_q <= '0;
                        shift_q   <= mem_q[0];
                    end
                end
                ST_SEND: begin
                    if (bit_end_d) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 5'd0) begin
                            if (last_led_d) begin
                                state_q     <= ST_LATCH;
                                latch_cnt_q <= LW'(TRESET - 1);
                            end else begin
                                // Snapshot of the next LED is taken as its first bit starts.
                                led_idx_q <= next_idx_d;
                                shift_q   <= mem_q[next_idx_d];
                                bit_idx_q <= 5'd23;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q - 5'd1;
                            shift_q   <= {shift_q[22:0], 1'b0};
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        fin_q   <= 1'b1;
                    end else begin
                        latch_cnt_q <= latch_cnt_q - LW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign led_data_out = led_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench for ws2812_chain_driver: a 2-LED chain at default timing and a
// 5-LED chain at shortened timing, decoded from measured high-pulse widths.
module tb_ws2812_chain_driver;

    localparam int T0H2 = 20, T1H2 = 40, TBIT2 = 63, TRST2 = 3000;
    localparam int T0H5 = 2,  T1H5 = 4,  TBIT5 = 6,  TRST5 = 20;
    localparam int FLEN2 = 2 * 24 * TBIT2 + TRST2;
    localparam int FLEN5 = 5 * 24 * TBIT5 + TRST5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wr_en2 = 1'b0, refresh2 = 1'b0;
    logic [0:0]  wr_addr2 = '0;
    logic [23:0] wr_color2 = '0;
    logic        busy2, done2, led2;

    logic        wr_en5 = 1'b0, refresh5 = 1'b0;
    logic [2:0]  wr_addr5 = '0;
    logic [23:0] wr_color5 = '0;
    logic        busy5, done5, led5;

    ws2812_chain_driver #(.NUM_LEDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_color(wr_color2), .refresh(refresh2), .busy(busy2), .done(done2),
        .led_data_out(led2)
    );

    ws2812_chain_driver #(.NUM_LEDS(5), .T0H(T0H5), .T1H(T1H5), .TBIT(TBIT5), .TRESET(TRST5)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .wr_color(wr_color5), .refresh(refresh5), .busy(busy5), .done(done5),
        .led_data_out(led5)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse-width / busy / done monitors
    int hw2[$], blen2[$], lowlen2[$];
    int hrun2 = 0, gap2 = 1000, per_bad2 = 0, brun2 = 0, lrun2 = 0, dcnt2 = 0, dbad2 = 0;
    logic led2_prev = 1'b0, busy2_prev = 1'b0;

    always @(negedge clk) begin
        if (led2 && !led2_prev) begin
            if (gap2 < 200 && gap2 != TBIT2) per_bad2++;
            gap2  = 1;
            hrun2 = 1;
        end else begin
            gap2++;
            if (led2) hrun2++;
        end
        if (!led2 && led2_prev) hw2.push_back(hrun2);
        led2_prev = led2;
        if (busy2) begin
            if (!busy2_prev) begin
                lowlen2.push_back(lrun2);
                lrun2 = 0;
            end
            brun2++;
        end else begin
            if (busy2_prev) begin
                blen2.push_back(brun2);
                brun2 = 0;
            end
            lrun2++;
        end
        busy2_prev = busy2;
        if (done2) begin
            dcnt2++;
            if (busy2) dbad2++;
        end
    end

    int hw5[$], blen5[$];
    int hrun5 = 0, brun5 = 0, dcnt5 = 0;
    logic led5_prev = 1'b0, busy5_prev = 1'b0;

    always @(negedge clk) begin
        if (led5) hrun5++;
        if (!led5 && led5_prev) begin
            hw5.push_back(hrun5);
            hrun5 = 0;
        end
        led5_prev = led5;
        if (busy5) brun5++;
        else if (busy5_prev) begin
            blen5.push_back(brun5);
            brun5 = 0;
        end
        busy5_prev = busy5;
        if (done5) dcnt5++;
    end

    task automatic clear2();
        hw2.delete(); blen2.delete(); lowlen2.delete();
        hrun2 = 0; per_bad2 = 0; brun2 = 0; lrun2 = 0; dcnt2 = 0; dbad2 = 0; gap2 = 1000;
    endtask

    task automatic clear5();
        hw5.delete(); blen5.delete();
        hrun5 = 0; brun5 = 0; dcnt5 = 0;
    endtask

    task automatic wr2(input logic [0:0] a, input logic [23:0] c);
        wr_en2 = 1'b1; wr_addr2 = a; wr_color2 = c;
        @(negedge clk);
        wr_en2 = 1'b0;
    endtask

    task automatic wr5(input logic [2:0] a, input logic [23:0] c);
        wr_en5 = 1'b1; wr_addr5 = a; wr_color5 = c;
        @(negedge clk);
        wr_en5 = 1'b0;
    endtask

    task automatic pulse2();
        refresh2 = 1'b1;
        @(negedge clk);
        refresh2 = 1'b0;
    endtask

    task automatic pulse5();
        refresh5 = 1'b1;
        @(negedge clk);
        refresh5 = 1'b0;
    endtask

    task automatic wait_done2(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done2 && n < 20000);
        check(tag, 32'(done2), 32'd1);
    endtask

    task automatic wait_done5(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done5 && n < 3000);
        check(tag, 32'(done5), 32'd1);
    endtask

    // Rebuild one LED's colour from 24 measured high widths (long high = 1).
    task automatic chk_led(input string tag, input bit sel5, input int base, input logic [23:0] exp);
        logic [23:0] val;
        int bad, w, t0, t1;
        val = '0;
        bad = 0;
        t0 = sel5 ? T0H5 : T0H2;
        t1 = sel5 ? T1H5 : T1H2;
        for (int i = 0; i < 24; i++) begin
            if (sel5) w = (base + i < hw5.size()) ? hw5[base + i] : 0;
            else      w = (base + i < hw2.size()) ? hw2[base + i] : 0;
            val = {val[22:0], (w == t1)};
            if (w != t0 && w != t1) bad++;
        end
        check(tag, 32'(val), 32'(exp));
        check({tag, "_widths"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [23:0] col5 [5];
    int quiet, d0;

    initial begin
        col5[0] = 24'hA50F3C; col5[1] = 24'h000001; col5[2] = 24'h800000;
        col5[3] = 24'hFFFFFF; col5[4] = 24'h5A5A5A;

        // Reset defaults
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_led2", 32'(led2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);
        check("rst_led5", 32'(led5), 32'd0);
        check("rst_busy5", 32'(busy5), 32'd0);
        rst_n = 1'b1;
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (led2 || busy2 || led5 || busy5) quiet++;
        end
        check("idle_quiet", 32'(quiet), 32'd0);

        // Single frame with latency check
        wr2(1'b0, 24'hFF0000);
        wr2(1'b1, 24'h0000A5);
        clear2();
        refresh2 = 1'b1;
        @(negedge clk);
        refresh2 = 1'b0;
        check("lat_busy_k", 32'(busy2), 32'd0);
        @(negedge clk);
        check("lat_busy_k1", 32'(busy2), 32'd1);
        check("lat_led_k1", 32'(led2), 32'd1);
        wait_done2("f1_done");
        @(negedge clk);
        check("f1_nbits", 32'(hw2.size()), 32'd48);
        chk_led("f1_led0", 1'b0, 0, 24'hFF0000);
        chk_led("f1_led1", 1'b0, 24, 24'h0000A5);
        check("f1_busy_len", 32'((blen2.size() > 0) ? blen2[0] : -1), 32'(FLEN2));
        check("f1_done_cnt", 32'(dcnt2), 32'd1);
        check("f1_done_busy", 32'(dbad2), 32'd0);
        check("f1_period", 32'(per_bad2), 32'd0);

        // Snapshot: LED1 write during LED0 lands now, LED0 write lands next frame
        clear2();
        pulse2();
        repeat (600) @(negedge clk);
        wr2(1'b1, 24'h123456);
        wr2(1'b0, 24'h00FF00);
        wait_done2("f2_done");
        @(negedge clk);
        chk_led("f2_led0", 1'b0, 0, 24'hFF0000);
        chk_led("f2_led1", 1'b0, 24, 24'h123456);

        // Write in the same cycle as LED1's load is not seen this frame
        clear2();
        refresh2 = 1'b1;
        @(negedge clk);
        refresh2 = 1'b0;
        repeat (1511) @(negedge clk);
        wr2(1'b1, 24'hABCDEF);
        wait_done2("f3_done");
        @(negedge clk);
        chk_led("f3_led0", 1'b0, 0, 24'h00FF00);
        chk_led("f3_led1", 1'b0, 24, 24'h123456);

        // Three refreshes while busy collapse into one extra frame
        clear2();
        pulse2();
        repeat (100) @(negedge clk);
        pulse2();
        repeat (200) @(negedge clk);
        pulse2();
        repeat (4800) @(negedge clk);
        pulse2();
        wait_done2("f4_done");
        wait_done2("f5_done");
        @(negedge clk);
        check("f45_nbits", 32'(hw2.size()), 32'd96);
        chk_led("f4_led0", 1'b0, 0, 24'h00FF00);
        chk_led("f4_led1", 1'b0, 24, 24'hABCDEF);
        chk_led("f5_led0", 1'b0, 48, 24'h00FF00);
        chk_led("f5_led1", 1'b0, 72, 24'hABCDEF);
        check("f45_nbusy", 32'(blen2.size()), 32'd2);
        check("f5_busy_len", 32'((blen2.size() > 1) ? blen2[1] : -1), 32'(FLEN2));
        check("f45_gap", 32'((lowlen2.size() == 2) ? lowlen2[1] : -1), 32'd1);
        check("f45_done_busy", 32'(dbad2), 32'd0);
        repeat (200) @(negedge clk);
        check("no_third_busy", 32'(busy2), 32'd0);
        check("f45_done_cnt", 32'(dcnt2), 32'd2);

        // 5-LED chain: baseline frame, then out-of-range writes change nothing
        for (int i = 0; i < 5; i++) wr5(3'(i), col5[i]);
        clear5();
        pulse5();
        wait_done5("g1_done");
        @(negedge clk);
        check("g1_nbits", 32'(hw5.size()), 32'd120);
        for (int i = 0; i < 5; i++) chk_led($sformatf("g1_led%0d", i), 1'b1, i * 24, col5[i]);
        check("g1_busy_len", 32'((blen5.size() > 0) ? blen5[0] : -1), 32'(FLEN5));
        wr5(3'd6, 24'hC3C3C3);
        wr5(3'd5, 24'hC3C3C3);
        wr5(3'd7, 24'hC3C3C3);
        clear5();
        pulse5();
        wait_done5("g2_done");
        @(negedge clk);
        check("g2_nbits", 32'(hw5.size()), 32'd120);
        for (int i = 0; i < 5; i++) chk_led($sformatf("g2_led%0d", i), 1'b1, i * 24, col5[i]);
        check("g2_done_cnt", 32'(dcnt5), 32'd1);

        // Reset in the middle of bit 10 of LED0 (a 1 bit of 00FF00)
        clear2();
        refresh2 = 1'b1;
        @(negedge clk);
        refresh2 = 1'b0;
        repeat (639) @(negedge clk);
        check("rst_pre_led", 32'(led2), 32'd1);
        d0 = dcnt2;
        #2 rst_n = 1'b0;
        #1;
        check("rst_led_now", 32'(led2), 32'd0);
        check("rst_busy_now", 32'(busy2), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3100) @(negedge clk);
        check("rst_no_done", 32'(dcnt2), 32'(d0));
        check("rst_stay_idle", 32'(busy2), 32'd0);
        clear2();
        pulse2();
        wait_done2("f6_done");
        @(negedge clk);
        check("f6_nbits", 32'(hw2.size()), 32'd48);
        chk_led("f6_led0", 1'b0, 0, 24'h000000);
        chk_led("f6_led1", 1'b0, 24, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
